// File: rtl/fp_minmax_reduce_if.sv
// Bundle of configuration, operand stream and result signals of the FP min/max
// reduction engine. The engine itself sits on the slave side.
interface fp_minmax_reduce_if #(
   parameter int CNT_W = 8
);
   logic             cfg_start;
   logic [CNT_W-1:0] cfg_len;
   logic             cfg_mode;
   logic             busy;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_data;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_data;
   logic [CNT_W-1:0] out_index;

   modport master (
      output cfg_start, cfg_len, cfg_mode, in_valid, in_data, out_ready,
      input  busy, in_ready, out_valid, out_data, out_index
   );

   modport slave (
      input  cfg_start, cfg_len, cfg_mode, in_valid, in_data, out_ready,
      output busy, in_ready, out_valid, out_data, out_index
   );
endinterface

// File: rtl/fp_minmax_reduce.sv
// Sequenced max/min reduction over a stream of IEEE-754 single words, one
// compare per cycle; returns the winning word and its first-occurrence index.
module fp_minmax_reduce #(
   parameter int CNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   fp_minmax_reduce_if.slave   bus,
   output logic [1:0]          dbg_state
);

   // Handshake: a beat transfers on a rising edge where valid && ready are both
   // high; valid, once raised by the producer, and its payload stay put until
   // that edge. in_ready and out_valid are registered and change only on edges.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] len_q;
   logic             mode_q;
   logic [CNT_W-1:0] count_q;
   logic [31:0]      win_q;
   logic [CNT_W-1:0] idx_q;
   logic             busy_q;
   logic             in_ready_q;
   logic             out_valid_q;

   // Total order on raw bits: sign first, then magnitude, inverted for negatives.
   function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
      logic r;
      if (a[31] != b[31])
         r = ~a[31];
      else if (!a[31])
         r = (a[30:0] > b[30:0]);
      else
         r = (a[30:0] < b[30:0]);
      return r;
   endfunction

   logic better;
   always_comb begin
      better = 1'b0;
      if (mode_q)
         better = fp_gt(win_q, bus.in_data);
      else
         better = fp_gt(bus.in_data, win_q);
   end

   logic last_beat;
   assign last_beat = (count_q == (len_q - 1'b1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         len_q       <= '0;
         mode_q      <= 1'b0;
         count_q     <= '0;
         win_q       <= '0;
         idx_q       <= '0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cfg_start) begin
                  busy_q <= 1'b1;
                  if (bus.cfg_len == '0) begin
                     win_q       <= '0;
                     idx_q       <= '0;
                     out_valid_q <= 1'b1;
                     state       <= DONE;
                  end else begin
                     len_q      <= bus.cfg_len;
                     mode_q     <= bus.cfg_mode;
                     count_q    <= '0;
                     in_ready_q <= 1'b1;
                     state      <= ACCUM;
                  end
               end
            end

            ACCUM: begin
               if (bus.in_valid) begin
                  // Strict compare so ties keep the earlier element.
                  if (count_q == '0 || better) begin
                     win_q <= bus.in_data;
                     idx_q <= count_q;
                  end
                  count_q <= count_q + 1'b1;
                  if (last_beat) begin
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                     state       <= DONE;
                  end
               end
            end

            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state       <= IDLE;
               end
            end

            default: begin
               busy_q      <= 1'b0;
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = win_q;
   assign bus.out_index = idx_q;
   assign dbg_state     = state;

endmodule

// File: tb/tb_fp_minmax_reduce.sv
// Directed, table-driven bench for fp_minmax_reduce with hand-computed results.
module tb_fp_minmax_reduce;

   localparam int CNT_W = 8;

   logic       clk;
   logic       rst;
   logic [1:0] dbg_state;

   fp_minmax_reduce_if #(.CNT_W(CNT_W)) bus ();

   fp_minmax_reduce #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string            name;
      int               len;
      logic             mode;
      logic [3:0][31:0] data;
      logic [31:0]      exp_data;
      logic [7:0]       exp_idx;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Start a reduction and stream the elements; only beats with in_ready high count.
   task automatic run_vec(input int len, input logic mode, input logic [3:0][31:0] d,
                          input logic toggle_valid, input logic inject_start,
                          input logic chk_lat, input string name);
      int   k;
      int   cyc;
      logic phase;
      @(negedge clk);
      bus.cfg_start = 1'b1;
      bus.cfg_len   = CNT_W'(len);
      bus.cfg_mode  = mode;
      bus.in_valid  = 1'b1;
      bus.in_data   = mode ? 32'hFF7F_FFFF : 32'h7F7F_FFFF;
      @(negedge clk);
      bus.cfg_start = 1'b0;
      k     = 0;
      cyc   = 1;
      phase = 1'b1;
      while (!bus.out_valid && cyc < 50) begin
         bus.cfg_start = 1'b0;
         if (inject_start && k == 2) begin
            bus.cfg_start = 1'b1;
            bus.cfg_len   = 8'd1;
            bus.cfg_mode  = ~mode;
         end
         if (bus.in_ready && k < len && (phase || !toggle_valid)) begin
            bus.in_valid = 1'b1;
            bus.in_data  = d[k];
            k++;
         end else begin
            bus.in_valid = 1'b0;
            bus.in_data  = mode ? 32'hFF00_0000 : 32'h7F00_0000;
         end
         phase = ~phase;
         @(negedge clk);
         cyc++;
      end
      bus.in_valid  = 1'b0;
      bus.cfg_start = 1'b0;
      chk({name, " out_valid"}, 32'(bus.out_valid), 32'd1);
      if (chk_lat)
         chk({name, " latency"}, 32'(cyc), 32'(len + 1));
   endtask

   // Check the result in DONE, optionally under backpressure, then consume it.
   task automatic take_result(input string name, input logic [31:0] exp_data,
                              input logic [7:0] exp_idx, input int hold);
      chk({name, " out_data"},  bus.out_data, exp_data);
      chk({name, " out_index"}, 32'(bus.out_index), 32'(exp_idx));
      chk({name, " in_ready"},  32'(bus.in_ready), 32'd0);
      chk({name, " busy"},      32'(bus.busy), 32'd1);
      chk({name, " state"},     32'(dbg_state), 32'd2);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({name, " hold out_valid"}, 32'(bus.out_valid), 32'd1);
         chk({name, " hold out_data"},  bus.out_data, exp_data);
         chk({name, " hold out_index"}, 32'(bus.out_index), 32'(exp_idx));
         chk({name, " hold in_ready"},  32'(bus.in_ready), 32'd0);
         chk({name, " hold busy"},      32'(bus.busy), 32'd1);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk({name, " drop out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({name, " idle busy"},      32'(bus.busy), 32'd0);
      chk({name, " idle state"},     32'(dbg_state), 32'd0);
   endtask

   initial begin
      vecs[0] = '{"max4",    4, 1'b0, {32'h3F00_0000, 32'h4000_0000, 32'hC040_0000, 32'h3F80_0000}, 32'h4000_0000, 8'd2};
      vecs[1] = '{"min4",    4, 1'b1, {32'h3F00_0000, 32'h4000_0000, 32'hC040_0000, 32'h3F80_0000}, 32'hC040_0000, 8'd1};
      vecs[2] = '{"maxneg",  2, 1'b0, {32'h0, 32'h0, 32'hBF80_0000, 32'hC040_0000}, 32'hBF80_0000, 8'd1};
      vecs[3] = '{"maxtie",  2, 1'b0, {32'h0, 32'h0, 32'h4000_0000, 32'h4000_0000}, 32'h4000_0000, 8'd0};
      vecs[4] = '{"maxzero", 2, 1'b0, {32'h0, 32'h0, 32'h0000_0000, 32'h8000_0000}, 32'h0000_0000, 8'd1};
      vecs[5] = '{"minzero", 2, 1'b1, {32'h0, 32'h0, 32'h0000_0000, 32'h8000_0000}, 32'h8000_0000, 8'd0};
      vecs[6] = '{"len0",    0, 1'b0, {32'h0, 32'h0, 32'h0, 32'h0}, 32'h0000_0000, 8'd0};
      vecs[7] = '{"maxnan",  3, 1'b0, {32'h0, 32'hFF80_0000, 32'h7FC0_0000, 32'h7F80_0000}, 32'h7FC0_0000, 8'd1};
      vecs[8] = '{"minnan",  3, 1'b1, {32'h0, 32'hFF80_0000, 32'h7FC0_0000, 32'h7F80_0000}, 32'hFF80_0000, 8'd2};

      rst           = 1'b1;
      bus.cfg_start = 1'b0;
      bus.cfg_len   = '0;
      bus.cfg_mode  = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset busy",      32'(bus.busy), 32'd0);
      chk("reset in_ready",  32'(bus.in_ready), 32'd0);
      chk("reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset out_data",  bus.out_data, 32'd0);
      chk("reset out_index", 32'(bus.out_index), 32'd0);
      chk("reset state",     32'(dbg_state), 32'd0);

      for (int i = 0; i < 9; i++) begin
         run_vec(vecs[i].len, vecs[i].mode, vecs[i].data, 1'b0, 1'b0, 1'b1, vecs[i].name);
         take_result(vecs[i].name, vecs[i].exp_data, vecs[i].exp_idx, 0);
      end

      // in_valid toggling: gap beats carry a large value that must be ignored
      run_vec(3, 1'b0, {32'h0, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000},
              1'b1, 1'b0, 1'b0, "toggle");
      take_result("toggle", 32'h4040_0000, 8'd1, 0);

      // cfg_start pulsed mid-ACCUM is ignored
      run_vec(vecs[0].len, vecs[0].mode, vecs[0].data, 1'b0, 1'b1, 1'b1, "midstart");
      take_result("midstart", 32'h4000_0000, 8'd2, 0);

      // backpressure in DONE
      run_vec(vecs[1].len, vecs[1].mode, vecs[1].data, 1'b0, 1'b0, 1'b1, "bkpr");
      take_result("bkpr", 32'hC040_0000, 8'd1, 4);

      // reset after 2 of 4 elements
      @(negedge clk);
      bus.cfg_start = 1'b1;
      bus.cfg_len   = 8'd4;
      bus.cfg_mode  = 1'b0;
      @(negedge clk);
      bus.cfg_start = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'h4000_0000;
      @(negedge clk);
      bus.in_data   = 32'h3F80_0000;
      @(negedge clk);
      bus.in_valid  = 1'b0;
      rst           = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort busy",      32'(bus.busy), 32'd0);
      chk("abort in_ready",  32'(bus.in_ready), 32'd0);
      chk("abort out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort out_data",  bus.out_data, 32'd0);
      chk("abort out_index", 32'(bus.out_index), 32'd0);
      chk("abort state",     32'(dbg_state), 32'd0);
      run_vec(1, 1'b0, {32'h0, 32'h0, 32'h0, 32'h3F00_0000}, 1'b0, 1'b0, 1'b1, "fresh");
      take_result("fresh", 32'h3F00_0000, 8'd0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
